// File: rtl/rv32i_defs.sv
// Shared definitions for the byte-wide sequencer around the single-cycle RV32 datapath.
package rv32i_defs;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned ByteIdxW     = $clog2(BytesPerWord);

  typedef enum logic [1:0] {
    LOAD,
    EXEC,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/instr_byte_sequencer_if.sv
// Pin-side byte streams plus core-side instruction/step/result signals of the sequencer.
interface instr_byte_sequencer_if #(
  parameter int unsigned COUNT_W = 16
);
  logic [7:0]         byte_in;
  logic               byte_valid;
  logic               byte_ready;
  logic [31:0]        instr;
  logic               core_step;
  logic [31:0]        alu_result;
  logic [7:0]         byte_out;
  logic               out_valid;
  logic               out_ready;
  logic [COUNT_W-1:0] instr_count;

  // Sequencer side.
  modport master (
    input  byte_in, byte_valid, alu_result, out_ready,
    output byte_ready, instr, core_step, byte_out, out_valid, instr_count
  );

  // Pin wrapper / core side.
  modport slave (
    output byte_in, byte_valid, alu_result, out_ready,
    input  byte_ready, instr, core_step, byte_out, out_valid, instr_count
  );
endinterface

// File: rtl/instr_byte_sequencer_serializer.sv
// word_serializer: unloads a captured 32-bit word as little-endian bytes under valid/ready.
module word_serializer
  import rv32i_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_valid,
  input  logic        i_ready,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  logic [31:0]         r_word;
  logic [ByteIdxW-1:0] r_oidx;
  logic [7:0]          r_byte;
  logic                w_xfer;
  logic [ByteIdxW-1:0] w_oidx_next;

  assign w_xfer      = i_valid & i_ready;
  assign w_oidx_next = r_oidx + ByteIdxW'(1);
  assign o_last      = w_xfer & (r_oidx == ByteIdxW'(BytesPerWord - 1));
  assign o_byte      = r_byte;

  // Output byte is pre-fetched into a register so byte_out never glitches while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_oidx <= '0;
      r_byte <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_oidx <= '0;
      r_byte <= i_word[7:0];
    end else if (w_xfer) begin
      r_oidx <= w_oidx_next;
      r_byte <= r_word[8*w_oidx_next +: 8];
    end
  end

endmodule

// File: rtl/instr_byte_sequencer.sv
// Assembles 32-bit instructions from bytes, steps the core once, and streams the result out.
module instr_byte_sequencer
  import rv32i_defs::*;
#(
  parameter bit          DRAIN_EN = 1'b1,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  instr_byte_sequencer_if.master  bus
);

  seq_state_t          r_state;
  seq_state_t          w_state_next;
  logic [ByteIdxW-1:0] r_idx;
  logic [31:0]         r_instr;
  logic [COUNT_W-1:0]  r_count;

  logic w_byte_ready;
  logic w_core_step;
  logic w_out_valid;
  logic w_accept;
  logic w_last_byte;
  logic w_drain_done;

  assign w_accept    = w_byte_ready & bus.byte_valid;
  assign w_last_byte = w_accept & (r_idx == ByteIdxW'(BytesPerWord - 1));

  // Handshake outputs depend only on state; rst masks them so nothing fires in the reset cycle.
  always_comb begin
    w_state_next = r_state;
    w_byte_ready = 1'b0;
    w_core_step  = 1'b0;
    w_out_valid  = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_byte_ready = ~rst;
        if (w_last_byte) w_state_next = EXEC;
      end
      EXEC: begin
        w_core_step  = ~rst;
        w_state_next = DRAIN_EN ? DRAIN : LOAD;
      end
      DRAIN: begin
        w_out_valid = ~rst;
        if (w_drain_done) w_state_next = LOAD;
      end
      default: w_state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_idx   <= '0;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_instr[8*r_idx +: 8] <= bus.byte_in;
        r_idx                 <= r_idx + ByteIdxW'(1);
      end
      if (w_core_step) r_count <= r_count + COUNT_W'(1);
    end
  end

  word_serializer u_serializer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_core_step),
    .i_word  (bus.alu_result),
    .i_valid (w_out_valid),
    .i_ready (bus.out_ready),
    .o_byte  (bus.byte_out),
    .o_last  (w_drain_done)
  );

  assign bus.byte_ready  = w_byte_ready;
  assign bus.core_step   = w_core_step;
  assign bus.out_valid   = w_out_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_count = r_count;

endmodule
